// File: rtl/ahb_axi4_wdata_ctrl.sv
// ahb_axi4_wdata_ctrl: write-data sequencer for the AHB-to-AXI4 bridge.
// Takes one burst command (AXI len = beats-1), pops exactly len+1 words from
// a show-ahead FIFO and presents them on a registered AXI4 W channel.
// Optional macro AHB_AXI4_WCTRL_UNDERRUN_CNT_EN adds a saturating count of
// cycles where the output could accept a beat but the FIFO was empty.
`timescale 1ns/1ps
module ahb_axi4_wdata_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_valid_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wvalid_o,
  output logic                  wlast_o,
  input  logic                  wready_i,
  output logic                  busy_o,
  output logic                  burst_done_o
`ifdef AHB_AXI4_WCTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt_o
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH:0]    fetch_cnt_q, fetch_cnt_d;   // one extra bit: len=max never wraps
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic                  burst_done_q, burst_done_d;

  logic in_burst, more_to_fetch, out_free, hs, load, accept;

  // Shared control terms
  always_comb begin
    in_burst      = (state_q == BURST);
    more_to_fetch = (fetch_cnt_q <= {1'b0, len_q});
    out_free      = !wvalid_q || wready_i;
    hs            = wvalid_q && wready_i;
    load          = in_burst && more_to_fetch && !fifo_empty_i && out_free;
    accept        = cmd_valid_i && (state_q == IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: leave BURST only on the handshake of the WLAST beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i)  state_d = BURST;
      BURST:   if (hs && wlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    busy_o      = (state_q == BURST);
  end

  // Datapath next values: a load refills the output stage, otherwise a
  // handshake drains it; a stalled beat simply holds
  always_comb begin
    len_d        = len_q;
    fetch_cnt_d  = fetch_cnt_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    burst_done_d = in_burst && hs && wlast_q;
    if (accept) begin
      len_d       = cmd_len_i;
      fetch_cnt_d = '0;
    end
    if (load) begin
      wdata_d     = fifo_data_i;
      wvalid_d    = 1'b1;
      wlast_d     = (fetch_cnt_q == {1'b0, len_q});
      fetch_cnt_d = fetch_cnt_q + 1'b1;
    end else if (hs) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      fetch_cnt_q  <= '0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      len_q        <= len_d;
      fetch_cnt_q  <= fetch_cnt_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Output wiring
  always_comb begin
    fifo_rd_valid_o = load;
    wdata_o         = wdata_q;
    wvalid_o        = wvalid_q;
    wlast_o         = wlast_q;
    burst_done_o    = burst_done_q;
  end

`ifdef AHB_AXI4_WCTRL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Underrun count: output could take a beat, burst still owes words, FIFO empty
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (in_burst && more_to_fetch && fifo_empty_i && out_free &&
        (underrun_cnt_q != 16'hFFFF))
      underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  // Underrun counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt_q <= '0;
    else        underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
